// File: rtl/arb_pkg.sv
// arb_pkg: state type and owner-index width helper shared by the DMA bus arbiter blocks.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, GRANT, TURN} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector; the first set request at or after ptr_i wins, wrapping modulo N.
module rr_picker import arb_pkg::*; #(
  parameter int N = 2,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  logic [W:0] s;
  // Scanning from the farthest offset down lets the nearest request overwrite earlier hits.
  always_comb begin
    idx_o = '0;
    s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, ptr_i} + (W+1)'(i);
      s = (s >= (W+1)'(N)) ? s - (W+1)'(N) : s;
      if (req_i[s[W-1:0]]) idx_o = s[W-1:0];
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: round-robin bus grant for NUM_CH DMA masters sharing the CPU memory port;
// drains the CPU's in-flight access before granting and asks long holders to yield.
module dma_bus_arbiter import arb_pkg::*; #(
  parameter int NUM_CH   = 2,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic                       Clk,
  input  logic                       Reset_N,
  input  logic [NUM_CH-1:0]          BR,
  input  logic                       cpu_bus_busy,
  output logic [NUM_CH-1:0]          BG,
  output logic                       cpu_hold,
  output logic [idx_w(NUM_CH)-1:0]   owner,
  output logic [NUM_CH-1:0]          preempt
);
  localparam int OW = idx_w(NUM_CH);
  arb_state_e        state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d, ptr_q, ptr_d, win;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [NUM_CH-1:0] bg_q, bg_d, pre_q, pre_d, own_oh;
  logic              hold_q, hold_d, win_valid, rival;

  rr_picker #(.N(NUM_CH), .W(OW)) u_pick (
    .req_i(BR), .ptr_i(ptr_q), .idx_o(win), .valid_o(win_valid)
  );

  assign own_oh  = NUM_CH'(1) << owner_q;
  assign rival   = |(BR & ~own_oh);
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bg_d    = bg_q;
    pre_d   = pre_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (win_valid) begin
        owner_d = win;
        hold_d  = 1'b1;
        state_d = cpu_bus_busy ? DRAIN : GRANT;
        bg_d    = cpu_bus_busy ? '0 : NUM_CH'(1) << win;
      end
      DRAIN: if (!BR[owner_q]) state_d = TURN;
        else if (!cpu_bus_busy) begin
          state_d = GRANT;
          bg_d    = own_oh;
        end
      GRANT: if (!BR[owner_q]) begin
        state_d = TURN;
        bg_d    = '0;
        pre_d   = '0;
        cnt_d   = '0;
        ptr_d   = (owner_q == OW'(NUM_CH - 1)) ? '0 : owner_q + 1'b1;
      end else begin
        cnt_d = cnt_inc;
        if (MAX_HOLD != 0 && cnt_inc >= CNT_W'(MAX_HOLD) && rival) pre_d = own_oh;
      end
      TURN: begin
        state_d = IDLE;
        hold_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      bg_q    <= '0;
      pre_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bg_q    <= bg_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
    end
  end

  assign BG       = bg_q;
  assign preempt  = pre_q;
  assign cpu_hold = hold_q;
  assign owner    = owner_q;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: directed scenarios plus randomized traffic checked against a behavioural arbiter model.
module tb_dma_bus_arbiter;
  localparam int N = 4, MH = 4, CW = 8;
  logic Clk = 1'b0, Reset_N = 1'b1, cpu_bus_busy = 1'b0, cpu_hold;
  logic [N-1:0] BR = '0, BG, preempt;
  logic [1:0] owner;
  int n_chk = 0, n_fail = 0;
  bit m_hold, m_grant, m_turn, m_pre;
  int m_owner, m_ptr, m_cnt;

  dma_bus_arbiter #(.NUM_CH(N), .MAX_HOLD(MH), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .BR(BR), .cpu_bus_busy(cpu_bus_busy),
    .BG(BG), .cpu_hold(cpu_hold), .owner(owner), .preempt(preempt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_grant = 0; m_turn = 0; m_pre = 0;
    m_owner = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // Applies the arbitration rules for one rising edge using the inputs present at that edge.
  task automatic model_step();
    if (m_turn) begin
      m_turn = 0;
      m_hold = 0;
    end else if (m_grant) begin
      if (!BR[m_owner]) begin
        m_grant = 0; m_turn = 1; m_pre = 0; m_cnt = 0;
        m_ptr = (m_owner + 1) % N;
      end else begin
        m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
        if (MH != 0 && m_cnt >= MH && (BR & ~(N'(1) << m_owner)) != 0) m_pre = 1;
      end
    end else if (m_hold) begin
      if (!BR[m_owner]) m_turn = 1;
      else if (!cpu_bus_busy) m_grant = 1;
    end else if (BR != 0) begin
      for (int i = 0; i < N; i++)
        if (BR[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          break;
        end
      m_hold = 1;
      m_grant = !cpu_bus_busy;
    end
  endtask

  task automatic check_all();
    chk("BG", BG, m_grant ? (32'd1 << m_owner) : 32'd0);
    chk("cpu_hold", cpu_hold, m_hold);
    chk("preempt", preempt, m_pre ? (32'd1 << m_owner) : 32'd0);
    if (m_hold) chk("owner", owner, m_owner);
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      check_all();
    end
  endtask

  initial begin
    #1 Reset_N = 1'b0;
    #2;
    chk("rst_bg", BG, 0); chk("rst_hold", cpu_hold, 0);
    chk("rst_pre", preempt, 0); chk("rst_owner", owner, 0);
    model_reset();
    @(negedge Clk); Reset_N = 1'b1;
    // single request and release timing
    BR = 4'b0001; cyc();
    chk("single_bg", BG, 4'b0001); chk("single_hold", cpu_hold, 1);
    BR = 4'b0000; cyc();
    chk("release_bg", BG, 0); chk("turn_hold", cpu_hold, 1);
    cyc();
    chk("idle_hold", cpu_hold, 0);
    // drain while the CPU access is in flight
    cpu_bus_busy = 1'b1; BR = 4'b0010; cyc();
    chk("drain_hold", cpu_hold, 1); chk("drain_bg0", BG, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); chk("drain_bg_wait", BG, 0);
    end
    cpu_bus_busy = 1'b0; cyc();
    chk("drain_bg", BG, 4'b0010);
    BR = 4'b0000; cyc(2);
    // async reset mid-grant
    BR = 4'b0100; cyc();
    chk("pre_reset_bg", BG, 4'b0100);
    cyc();
    #2 Reset_N = 1'b0;
    #1;
    chk("async_bg", BG, 0); chk("async_hold", cpu_hold, 0); chk("async_pre", preempt, 0);
    model_reset();
    @(negedge Clk); BR = 4'b1111; Reset_N = 1'b1;
    // round robin with all channels requesting, ch0 first after reset
    for (int g = 0; g < 5; g++) begin
      cyc(); chk("rr_bg", BG, 32'd1 << (g % N));
      cyc();
      BR = 4'b1111 & ~(N'(1) << (g % N)); cyc();
      chk("rr_turn_bg", BG, 0);
      BR = 4'b1111; cyc();
      chk("rr_idle_hold", cpu_hold, 0);
    end
    BR = 4'b0000; cyc();
    // preemption with a competitor present
    BR = 4'b0001; cyc();
    chk("pre_grant", BG, 4'b0001);
    BR = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("pre_early", preempt, 0);
    end
    cyc(); chk("pre_assert", preempt, 4'b0001);
    cyc(2); chk("pre_stay", preempt, 4'b0001);
    BR = 4'b0010; cyc();
    chk("pre_clear", preempt, 0); chk("pre_rel_bg", BG, 0);
    BR = 4'b0000; cyc(2);
    // no competitor, no preemption
    BR = 4'b0001; cyc();
    for (int i = 0; i < 8; i++) begin
      cyc(); chk("pre_alone", preempt, 0);
    end
    BR = 4'b0000; cyc(2);
    // request abandoned during drain leaves the pointer untouched
    cpu_bus_busy = 1'b1; BR = 4'b0010; cyc();
    chk("ab_hold", cpu_hold, 1); chk("ab_bg", BG, 0);
    BR = 4'b0000; cyc();
    chk("ab_turn_bg", BG, 0); chk("ab_turn_hold", cpu_hold, 1);
    cyc();
    chk("ab_idle_hold", cpu_hold, 0);
    cpu_bus_busy = 1'b0; BR = 4'b0011; cyc();
    chk("ab_ptr", BG, 4'b0010);
    BR = 4'b0000; cyc(2);
    // randomized traffic with sticky requests
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) BR[b] = ~BR[b];
      cpu_bus_busy = ($urandom_range(2) == 0);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
